// File: rtl/seq_ctrl_if.sv
// Control bus between the SISC sequencer and the datapath.
//   opcode, mm : IR[31:28], IR[27:24]
//   stat       : status register {C,N,V,Z}
//   mem_rdy    : data-memory done (only with SEQ_MEM_WAIT_EN)
//   pc_*, br_sel, ir_load, alu_op, rb_sel, rf_we, wb_sel, dm_we : datapath controls
//   halted, state : sequencer status / debug
// master = sequencer side, slave = datapath side.
interface seq_ctrl_if;
  logic [3:0] opcode;
  logic [3:0] mm;
  logic [3:0] stat;
`ifdef SEQ_MEM_WAIT_EN
  logic       mem_rdy;
`endif
  logic       pc_rst;
  logic       pc_write;
  logic       pc_sel;
  logic       br_sel;
  logic       ir_load;
  logic [1:0] alu_op;
  logic       rb_sel;
  logic       rf_we;
  logic       wb_sel;
  logic       dm_we;
  logic       halted;
  logic [2:0] state;

  modport master (
`ifdef SEQ_MEM_WAIT_EN
    input  mem_rdy,
`endif
    input  opcode, mm, stat,
    output pc_rst, pc_write, pc_sel, br_sel, ir_load, alu_op, rb_sel, rf_we, wb_sel,
           dm_we, halted, state
  );

  modport slave (
`ifdef SEQ_MEM_WAIT_EN
    output mem_rdy,
`endif
    output opcode, mm, stat,
    input  pc_rst, pc_write, pc_sel, br_sel, ir_load, alu_op, rb_sel, rf_we, wb_sel,
           dm_we, halted, state
  );
endinterface

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer for the SISC core.
// Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK and
// decodes the datapath controls combinationally from state, opcode, mm and stat.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (returns to START0 from any state)
//   bus  : seq_ctrl_if.master (IR fields and status in, datapath controls out)
// Build option: define SEQ_MEM_WAIT_EN to stall in MEM until bus.mem_rdy is high.
module seq_ctrl (
  input  logic          clk,
  input  logic          rst,
  seq_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    StStart0    = 3'd0,
    StStart1    = 3'd1,
    StFetch     = 3'd2,
    StDecode    = 3'd3,
    StExecute   = 3'd4,
    StMem       = 3'd5,
    StWriteback = 3'd6,
    StHalt      = 3'd7
  } state_e;

  localparam logic [3:0] OpAlu = 4'h1;
  localparam logic [3:0] OpBra = 4'h2;
  localparam logic [3:0] OpBrr = 4'h3;
  localparam logic [3:0] OpBne = 4'h4;
  localparam logic [3:0] OpBnr = 4'h5;
  localparam logic [3:0] OpLod = 4'h6;
  localparam logic [3:0] OpStr = 4'h7;
  localparam logic [3:0] OpHlt = 4'hf;

  state_e state_q, state_d;

  logic       pc_rst, pc_write, pc_sel, br_sel, ir_load;
  logic [1:0] alu_op;
  logic       rb_sel, rf_we, wb_sel, dm_we, halted;

  logic       is_alu, is_lod, is_str;
  logic       br_on_set, br_on_clr, mask_hit, br_taken, br_abs;
  logic       mem_done;

  assign is_alu    = (bus.opcode == OpAlu);
  assign is_lod    = (bus.opcode == OpLod);
  assign is_str    = (bus.opcode == OpStr);
  assign br_on_set = (bus.opcode == OpBra) || (bus.opcode == OpBrr);
  assign br_on_clr = (bus.opcode == OpBne) || (bus.opcode == OpBnr);
  assign mask_hit  = |(bus.mm & bus.stat);
  assign br_taken  = (br_on_set && mask_hit) || (br_on_clr && !mask_hit);
  assign br_abs    = (bus.opcode == OpBra) || (bus.opcode == OpBne);

`ifdef SEQ_MEM_WAIT_EN
  assign mem_done = bus.mem_rdy;
`else
  assign mem_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StStart0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    ir_load  = 1'b0;
    alu_op   = 2'b00;
    rb_sel   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    dm_we    = 1'b0;
    halted   = 1'b0;

    unique case (state_q)
      StStart0: begin
        pc_rst  = 1'b1;
        state_d = StStart1;
      end
      StStart1: state_d = StFetch;
      StFetch: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        state_d  = StDecode;
      end
      StDecode: begin
        // An untaken branch leaves the PC+1 loaded in FETCH in place.
        if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = br_abs;
        end
        if (bus.opcode == OpHlt) begin
          state_d = StHalt;
        end else if (is_alu || is_lod || is_str) begin
          state_d = StExecute;
        end else begin
          state_d = StFetch;  // NOP, branches and illegal 8..E
        end
      end
      StExecute: begin
        if (is_alu) begin
          alu_op  = {1'b0, bus.mm[3]};
          state_d = StWriteback;
        end else begin
          alu_op  = 2'b10;
          rb_sel  = is_str;
          state_d = (is_lod || is_str) ? StMem : StFetch;
        end
      end
      StMem: begin
        alu_op = 2'b10;
        rb_sel = is_str;
        dm_we  = is_str;
        if (mem_done) begin
          state_d = is_lod ? StWriteback : StFetch;
        end
      end
      StWriteback: begin
        rf_we   = 1'b1;
        wb_sel  = is_lod;
        alu_op  = is_alu ? {1'b0, bus.mm[3]} : 2'b10;
        state_d = StFetch;
      end
      StHalt: halted = 1'b1;
      default: state_d = StStart0;
    endcase
  end

  assign bus.pc_rst   = pc_rst;
  assign bus.pc_write = pc_write;
  assign bus.pc_sel   = pc_sel;
  assign bus.br_sel   = br_sel;
  assign bus.ir_load  = ir_load;
  assign bus.alu_op   = alu_op;
  assign bus.rb_sel   = rb_sel;
  assign bus.rf_we    = rf_we;
  assign bus.wb_sel   = wb_sel;
  assign bus.dm_we    = dm_we;
  assign bus.halted   = halted;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: directed cases followed by random
// instructions, each expanded by a reference model into its per-cycle
// control schedule and compared cycle by cycle.
module tb_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_ctrl_if bus ();

  seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       pc_rst;
    logic       pc_write;
    logic       pc_sel;
    logic       br_sel;
    logic       ir_load;
    logic [1:0] alu_op;
    logic       rb_sel;
    logic       rf_we;
    logic       wb_sel;
    logic       dm_we;
    logic       halted;
    logic [2:0] state;
  } ctl_t;

  ctl_t obs;
  assign obs = {bus.pc_rst, bus.pc_write, bus.pc_sel, bus.br_sel, bus.ir_load, bus.alu_op,
                bus.rb_sel, bus.rf_we, bus.wb_sel, bus.dm_we, bus.halted, bus.state};

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Compare one cycle at the falling edge, then move just past the next rising edge.
  task automatic run_cycle(input string tag, input ctl_t want);
    @(negedge clk);
    check(tag, 32'(obs), 32'(want));
    @(posedge clk);
    #1;
  endtask

  function automatic ctl_t w_state(input logic [2:0] s);
    ctl_t w;
    w = '0;
    w.state = s;
    return w;
  endfunction

  // Caller has rst high across one edge already; this checks START0, START1.
  task automatic reset_tail(input string tag);
    ctl_t w;
    w = w_state(3'd0);
    w.pc_rst = 1'b1;
    rst = 1'b0;
    run_cycle({tag, "_start0"}, w);
    run_cycle({tag, "_start1"}, w_state(3'd1));
  endtask

  task automatic do_reset();
    ctl_t w;
    rst = 1'b1;
    @(posedge clk);
    #1;
    w = w_state(3'd0);
    w.pc_rst = 1'b1;
    run_cycle("rst_hold", w);
    reset_tail("rst");
  endtask

  // Expand one instruction into its expected cycle schedule from FETCH up to
  // (not including) the next FETCH, then play it against the DUT. inj >= 0
  // raises rst during that schedule entry.
  task automatic exec_instr(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] st,
                            input int inj);
    ctl_t seq[$];
    ctl_t w;
    bit   taken;
    string tag;

    w = w_state(3'd2);
    w.ir_load  = 1'b1;
    w.pc_write = 1'b1;
    seq.push_back(w);

    w = w_state(3'd3);
    if (op inside {4'h2, 4'h3, 4'h4, 4'h5}) begin
      taken = (op <= 4'h3) ? ((mm & st) != 4'h0) : ((mm & st) == 4'h0);
      if (taken) begin
        w.pc_write = 1'b1;
        w.pc_sel   = 1'b1;
        w.br_sel   = (op == 4'h2) || (op == 4'h4);
      end
    end
    seq.push_back(w);

    case (op)
      4'h1: begin
        w = w_state(3'd4); w.alu_op = {1'b0, mm[3]}; seq.push_back(w);
        w = w_state(3'd6); w.alu_op = {1'b0, mm[3]}; w.rf_we = 1'b1; seq.push_back(w);
      end
      4'h6: begin
        w = w_state(3'd4); w.alu_op = 2'b10; seq.push_back(w);
        w = w_state(3'd5); w.alu_op = 2'b10; seq.push_back(w);
        w = w_state(3'd6); w.alu_op = 2'b10; w.rf_we = 1'b1; w.wb_sel = 1'b1; seq.push_back(w);
      end
      4'h7: begin
        w = w_state(3'd4); w.alu_op = 2'b10; w.rb_sel = 1'b1; seq.push_back(w);
        w = w_state(3'd5); w.alu_op = 2'b10; w.rb_sel = 1'b1; w.dm_we = 1'b1; seq.push_back(w);
      end
      4'hf: begin
        w = w_state(3'd7);
        w.halted = 1'b1;
        for (int i = 0; i < 10; i++) seq.push_back(w);
      end
      default: ;
    endcase

    for (int k = 0; k < seq.size(); k++) begin
      tag = $sformatf("op%0h_mm%0h_st%0h_c%0d", op, mm, st, k);
      if (k == inj) rst = 1'b1;
`ifdef SEQ_MEM_WAIT_EN
      bus.mem_rdy = ($urandom_range(0, 3) != 0);
`endif
      run_cycle(tag, seq[k]);
      if (k == 0) begin
        bus.opcode = op;
        bus.mm     = mm;
        bus.stat   = st;
      end
      if (rst) begin
        reset_tail({tag, "_rst"});
        return;
      end
`ifdef SEQ_MEM_WAIT_EN
      if (seq[k].state == 3'd5 && !bus.mem_rdy) k--;
`endif
    end
    if (op == 4'hf) do_reset();
  endtask

  initial begin
    logic [3:0] op, mm, st;
    int inj;

    bus.opcode = 4'h0;
    bus.mm     = 4'h0;
    bus.stat   = 4'h0;
`ifdef SEQ_MEM_WAIT_EN
    bus.mem_rdy = 1'b1;
`endif
    do_reset();

    exec_instr(4'h1, 4'h0, 4'h0, -1);  // ALU reg-reg
    exec_instr(4'h1, 4'h8, 4'h0, -1);  // ALU reg-imm
    exec_instr(4'h2, 4'h1, 4'h1, -1);  // BRA taken
    exec_instr(4'h3, 4'h2, 4'h1, -1);  // BRR not taken
    exec_instr(4'h5, 4'h2, 4'h1, -1);  // BNR taken, relative
    exec_instr(4'h4, 4'h0, 4'h1, -1);  // BNE mm=0 always taken
    exec_instr(4'h2, 4'h0, 4'hf, -1);  // BRA mm=0 never taken
    exec_instr(4'h6, 4'h0, 4'h0, -1);  // LOD
    exec_instr(4'h7, 4'h0, 4'h0, -1);  // STR
    exec_instr(4'ha, 4'h3, 4'h3, -1);  // illegal as NOP
    exec_instr(4'h7, 4'h0, 4'h0, 3);   // reset during STR MEM
    exec_instr(4'hf, 4'h0, 4'h0, -1);  // HLT then reset

    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hf && $urandom_range(0, 3) != 0) op = 4'h0;
      mm  = 4'($urandom_range(0, 15));
      st  = 4'($urandom_range(0, 15));
      inj = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
      exec_instr(op, mm, st, inj);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
